// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the word memory controller and its byte RAM.
package mem_ctrl_pkg;
`include "definitions.svh"

    localparam int WORD_BYTES_DEF = 4;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} mem_ctrl_state_t;
endpackage

// File: rtl/ram_bus.sv
// Byte-wide RAM bus between the word controller (master) and the RAM (slave).
interface ram_bus;
    import mem_ctrl_pkg::*;

    logic             we;
    logic [BYTE-1:0]  data;
    logic [NBITS-1:0] addr;
    logic [BYTE-1:0]  q;

    modport master (output we, output data, output addr, input q);
    modport slave  (input we, input data, input addr, output q);
endinterface

// File: rtl/definitions.svh
// Global widths shared by the memory subsystem: byte width and byte-address width.
`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH
localparam int BYTE  = 8;
localparam int NBITS = 16;
`endif

// File: rtl/ram.sv
// Byte-wide synchronous RAM with one-cycle registered read data.
module ram
    import mem_ctrl_pkg::*;
(
    input  logic   clk,
    ram_bus.slave  bus
);
    logic [BYTE-1:0] mem [2**NBITS];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.addr] <= bus.data;
        end
        bus.q <= mem[bus.addr];
    end
endmodule

// File: rtl/word_mem_ctrl.sv
// Word-access controller: splits one word request into big-endian byte accesses on a byte RAM.
// Optional single-byte accesses are enabled with the WORD_MEM_BYTE_ACCESS_EN macro.
//
// state | meaning
// IDLE  | ready for a request, bus quiet at the last base address
// WRITE | one byte written per cycle, cnt selects the lane
// READ  | one address per cycle, read data captured one cycle behind the address
// DONE  | one-cycle response pulse
module word_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [NBITS-1:0]           req_addr,
    input  logic [WORD_BYTES*BYTE-1:0] req_wdata,
`ifdef WORD_MEM_BYTE_ACCESS_EN
    input  logic                       req_byte,
`endif
    output logic                       rsp_valid,
    output logic [WORD_BYTES*BYTE-1:0] rsp_rdata,
    ram_bus.master                     bus
);
    localparam int W  = WORD_BYTES*BYTE;
    localparam int CW = $clog2(WORD_BYTES+1);
    localparam logic [CW-1:0] WR_LAST_WORD = CW'(WORD_BYTES-1);
    localparam logic [CW-1:0] RD_LAST_WORD = CW'(WORD_BYTES);

    mem_ctrl_state_t  state;
    logic [NBITS-1:0] base;
    logic [W-1:0]     wbuf;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    wr_last;
    logic [CW-1:0]    rd_last;
    logic [NBITS-1:0] addr_nxt;
    logic [BYTE-1:0]  wbyte_nxt;
    logic [W-1:0]     rdata_upd;
    logic             byte_req;
    logic             byte_mode;

`ifdef WORD_MEM_BYTE_ACCESS_EN
    assign byte_req = req_byte;
`else
    assign byte_req  = 1'b0;
    assign byte_mode = 1'b0;
`endif

    assign req_ready = rst_n && (state == IDLE);
    assign cnt_nxt   = cnt + 1'b1;
    assign wr_last   = byte_mode ? '0 : WR_LAST_WORD;
    assign rd_last   = byte_mode ? CW'(1) : RD_LAST_WORD;
    assign addr_nxt  = base + NBITS'(cnt_nxt);

    always_comb begin
        wbyte_nxt = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (cnt_nxt == CW'(k)) begin
                wbyte_nxt = wbuf[W-1-k*BYTE -: BYTE];
            end
        end
    end

    // RAM data lags the address by one cycle, so count n lands in lane n-1
    always_comb begin
        rdata_upd = rsp_rdata;
        if (byte_mode) begin
            rdata_upd = W'(bus.q);
        end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (cnt == CW'(k+1)) begin
                    rdata_upd[W-1-k*BYTE -: BYTE] = bus.q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            wbuf      <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.data  <= '0;
`ifdef WORD_MEM_BYTE_ACCESS_EN
            byte_mode <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base     <= req_addr;
                        cnt      <= '0;
                        bus.addr <= req_addr;
                        bus.we   <= req_we;
`ifdef WORD_MEM_BYTE_ACCESS_EN
                        byte_mode <= req_byte;
`endif
                        // a lone byte is parked in lane 0 so the write path is shared
                        if (byte_req) begin
                            wbuf     <= req_wdata << (W-BYTE);
                            bus.data <= req_wdata[BYTE-1:0];
                        end else begin
                            wbuf     <= req_wdata;
                            bus.data <= req_wdata[W-1 -: BYTE];
                        end
                        state <= req_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    cnt <= cnt_nxt;
                    if (cnt == wr_last) begin
                        state     <= DONE;
                        bus.we    <= 1'b0;
                        bus.addr  <= base;
                        rsp_valid <= 1'b1;
                    end else begin
                        bus.addr <= addr_nxt;
                        bus.data <= wbyte_nxt;
                    end
                end
                READ: begin
                    cnt <= cnt_nxt;
                    if (cnt != '0) begin
                        rsp_rdata <= rdata_upd;
                    end
                    if (cnt == rd_last) begin
                        state     <= DONE;
                        bus.addr  <= base;
                        rsp_valid <= 1'b1;
                    end else begin
                        bus.addr <= addr_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_mem_ctrl.sv
// Scoreboard bench for word_mem_ctrl attached to the byte RAM over one ram_bus.
module tb_word_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int WB       = WORD_BYTES_DEF;
    localparam int W        = WB*BYTE;
    localparam int MEM_SIZE = 2**NBITS;

    typedef struct {
        bit           chk_data;
        logic [W-1:0] rdata;
        int           due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_we = 1'b0;
    logic             req_byte = 1'b0;
    logic [NBITS-1:0] req_addr = '0;
    logic [W-1:0]     req_wdata = '0;
    logic             req_ready;
    logic             rsp_valid;
    logic [W-1:0]     rsp_rdata;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   busy_from = 1, busy_until = 0;
    int   we_from = 1, we_until = 0;
    exp_t sb[$];
    logic [BYTE-1:0] mdl [int];

    ram_bus bus();

    ram u_ram (.clk(clk), .bus(bus));

    word_mem_ctrl #(.WORD_BYTES(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef WORD_MEM_BYTE_ACCESS_EN
        .req_byte  (req_byte),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: ready/we follow the bench's own timing windows, responses pop the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && mon_en) begin
            check("req_ready", req_ready, 64'(!(cyc >= busy_from && cyc <= busy_until)));
            check("bus_we", bus.we, 64'(cyc >= we_from && cyc <= we_until));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_cycle", cyc, e.due);
                    if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance with req_valid low
    task automatic issue(input bit we, input logic [NBITS-1:0] addr, input logic [W-1:0] wd,
                         input bit bm, output int acc);
        exp_t e;
        int   waited;
        int   n;
        int   a;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_byte  = bm;
        waited    = 0;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("req_accept", req_ready, 1);
        acc        = cyc;
        n          = bm ? 1 : WB;
        e.chk_data = !we;
        e.rdata    = '0;
        for (int i = 0; i < n; i++) begin
            a = (int'(addr) + i) % MEM_SIZE;
            if (we) begin
                mdl[a] = bm ? wd[BYTE-1:0] : wd[W-1-i*BYTE -: BYTE];
            end else if (mdl.exists(a)) begin
                e.rdata = (e.rdata << BYTE) | W'(mdl[a]);
            end else begin
                e.chk_data = 1'b0;
            end
        end
        if (we) begin
            e.due    = acc + n + 1;
            we_from  = acc + 1;
            we_until = acc + n;
        end else begin
            e.due = acc + n + 2;
        end
        busy_from  = acc + 1;
        busy_until = e.due;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_byte  = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin : stim
        int a1, a2, d1;
        logic [NBITS-1:0] ra;
        logic [W-1:0]     rw;
        bit bm;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_bus_we", bus.we, 0);
        check("rst_bus_addr", bus.addr, 0);
        check("rst_bus_data", bus.data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        mon_en = 1'b1;

        // Word write then read
        issue(1'b1, NBITS'(16'h0010), W'(32'hDEADBEEF), 1'b0, a1);
        wait_idle();
        check("ram_10", u_ram.mem[16'h0010], 8'hDE);
        check("ram_11", u_ram.mem[16'h0011], 8'hAD);
        check("ram_12", u_ram.mem[16'h0012], 8'hBE);
        check("ram_13", u_ram.mem[16'h0013], 8'hEF);
        issue(1'b0, NBITS'(16'h0010), '0, 1'b0, a1);
        wait_idle();
        check("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);

        // Address wrap at the top of memory
        issue(1'b1, NBITS'(MEM_SIZE-2), W'(32'h01020304), 1'b0, a1);
        wait_idle();
        check("ram_wrap0", u_ram.mem[MEM_SIZE-2], 8'h01);
        check("ram_wrap1", u_ram.mem[MEM_SIZE-1], 8'h02);
        check("ram_wrap2", u_ram.mem[0], 8'h03);
        check("ram_wrap3", u_ram.mem[1], 8'h04);
        issue(1'b0, NBITS'(MEM_SIZE-2), '0, 1'b0, a1);
        wait_idle();

        // Back-to-back writes with req_valid held high across the handoff
        issue(1'b1, NBITS'(16'h0020), W'(32'hA1B2C3D4), 1'b0, a1);
        d1 = a1 + WB + 1;
        issue(1'b1, NBITS'(16'h0024), W'(32'h55667788), 1'b0, a2);
        check("b2b_accept", a2, d1 + 1);
        wait_idle();
        issue(1'b0, NBITS'(16'h0020), '0, 1'b0, a1);
        issue(1'b0, NBITS'(16'h0022), '0, 1'b0, a1);
        wait_idle();

        // Reset in cycle A+2 of a read
        issue(1'b0, NBITS'(16'h0024), '0, 1'b0, a1);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        busy_from  = 1;
        busy_until = 0;
        repeat (2) @(negedge clk);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_bus_we", bus.we, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_rdata", rsp_rdata, 0);
        check("rstmid_ready", req_ready, 1);
        repeat (8) @(negedge clk);

`ifdef WORD_MEM_BYTE_ACCESS_EN
        issue(1'b1, NBITS'(16'h0030), W'(32'h11223344), 1'b0, a1);
        issue(1'b1, NBITS'(16'h0031), W'(32'hFFFFFFAB), 1'b1, a1);
        wait_idle();
        check("byte_ram30", u_ram.mem[16'h0030], 8'h11);
        check("byte_ram31", u_ram.mem[16'h0031], 8'hAB);
        check("byte_ram32", u_ram.mem[16'h0032], 8'h33);
        issue(1'b0, NBITS'(16'h0031), '0, 1'b1, a1);
        wait_idle();
        check("byte_rd", rsp_rdata, 32'h000000AB);
`endif

        // Random write/read-back pairs with idle gaps
        for (int it = 0; it < 24; it++) begin
            ra = NBITS'($urandom_range(0, MEM_SIZE-1));
            rw = W'($urandom);
            bm = 1'b0;
`ifdef WORD_MEM_BYTE_ACCESS_EN
            bm = 1'($urandom_range(0, 1));
`endif
            issue(1'b1, ra, rw, bm, a1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef WORD_MEM_BYTE_ACCESS_EN
            bm = 1'($urandom_range(0, 1));
`endif
            issue(1'b0, ra, '0, bm, a1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
